chip8_exec_unit: RTL and testbench
==================================

Name: chip8_exec_unit

Overview:
- Parametrised successor of the CHIP-8 CPU register/ALU datapath.
- Holds the V register file and executes the 6XNN, 7XNN and 8XYn instruction groups.
- Instructions enter through a valid/ready handshake from the fetch/decode logic.
- Configurable data width, register count and the two common CHIP-8 ALU quirks.
- Two combinational debug read ports expose registers to the bench and the Avalon/VGA debug path.

Parameters:
- DATA_W, 8: width of each V register.
- NUM_REGS, 16: number of V registers, 2..16. The flag register is index NUM_REGS-1.
- SHIFT_QUIRK, 0: 0 = 8XY6/8XYE shift VY into VX. 1 = shift VX in place.
- VF_RESET, 1: 1 = 8XY1/8XY2/8XY3 clear the flag register. 0 = flag untouched.

Ports:
- cpu_clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction present
- instruction  in  16  opcode
- instr_ready  out  1  unit can accept
- done  out  1  one-cycle pulse at writeback
- illegal  out  1  one-cycle pulse for an unsupported/out-of-range opcode
- testIn1  in  4  debug read address 1
- testIn2  in  4  debug read address 2
- testOut1  out  DATA_W  V[testIn1], combinational; 0 if address >= NUM_REGS
- testOut2  out  DATA_W  V[testIn2], same rules

Behaviour:
- Reset (async assert, sync release):
  - All V registers = 0, FSM = IDLE.
  - instr_ready = 1, done = 0, illegal = 0.
  - Reset mid-EXEC discards the in-flight instruction; no write occurs.
- FSM IDLE:
  - instr_ready = 1.
  - On instr_valid at a rising edge, latch the opcode, read VX/VY, go to EXEC.
- FSM EXEC:
  - instr_ready = 0.
  - At the next edge: write back, pulse done (or illegal), return to IDLE.
  - One instruction per 2 cycles.
  - instr_valid in EXEC is ignored; the source must hold it until the handshake.
- Latency: the result is visible on testOut ports the cycle after the done edge, i.e. 2 edges after acceptance.
- Decode; X = instr[11:8], Y = instr[7:4], NN = instr[7:0] zero-extended/truncated to DATA_W:
  - 6XNN: VX = NN.
  - 7XNN: VX = VX + NN mod 2^DATA_W; flag untouched.
  - 8XY0: VX = VY.
  - 8XY1 / 8XY2 / 8XY3: OR / AND / XOR; flag per VF_RESET.
  - 8XY4: VX = VX + VY; flag = carry out of bit DATA_W-1.
  - 8XY5: VX = VX - VY; flag = 1 if VX >= VY (no borrow).
  - 8XY6: src >> 1; flag = src[0].
  - 8XY7: VX = VY - VX; flag = 1 if VY >= VX.
  - 8XYE: src << 1; flag = src[DATA_W-1].
  - For 8XY6/8XYE, src = VY when SHIFT_QUIRK = 0, VX when SHIFT_QUIRK = 1.
- Flag values are computed from operands latched before writeback.
- If X == flag index, the flag write wins over the result.
- Illegal: other nibbles of the 8 group, other top nibbles, or X/Y >= NUM_REGS → no register write, pulse illegal, done stays 0.

Decomposition:
- chip8_pkg holds:
  - opcode-group constants OP_LD = 4'h6, OP_ADD = 4'h7, OP_ALU = 4'h8;
  - ALU sub-op enum alu_op_t (MOV, OR, AND, XOR, ADD, SUB, SHR, SUBN, SHL);
  - state enum exec_state_t {IDLE, EXEC}.
- Sub-module chip8_alu: purely combinational. Takes alu_op_t, operands and quirk parameters; returns {result, flag, flag_we}.
- Register file and FSM stay in chip8_exec_unit.

Test Plan:
- Default params: 6122, 6020, 8014 → V0 = 0x42, V1 = 0x22, VF = 0; done pulses 3 times; illegal never asserted.
- Continue: 8014 → V0 = 0x64; 8013 → V0 = 0x46, VF = 0; 8015 → V0 = 0x24, VF = 1; 8017 (V0 = 0x24, V1 = 0x22) → V0 = 0xFE, VF = 0.
- Carry/flag precedence:
  - 60FF, 6101, 8014 → V0 = 0x00, VF = 1.
  - 6FFF, 8F14 (V1 = 0x01) → VF = 1, not the sum 0x00.
- Shift quirk:
  - 6181, 6003, 8016 with SHIFT_QUIRK = 0 → V0 = 0x40, VF = 1.
  - Same with SHIFT_QUIRK = 1 → V0 = 0x01, VF = 1.
- Handshake/illegal:
  - instr_valid held with a new opcode during EXEC → ignored until instr_ready = 1.
  - 801F → illegal pulse, no register change.
  - NUM_REGS = 8 with 6922 → illegal.
- Reset: reset_n low during EXEC of 6055 → V0 = 0 and instr_ready = 1 immediately (asynchronously), no done pulse; DATA_W = 12 run of 60FF, 7001 → V0 = 0x100.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared opcode constants and enums for the CHIP-8 execution unit.
package chip8_pkg;

  localparam logic [3:0] OP_LD  = 4'h6;
  localparam logic [3:0] OP_ADD = 4'h7;
  localparam logic [3:0] OP_ALU = 4'h8;

  typedef enum logic [3:0] {
    ALU_MOV, ALU_OR, ALU_AND, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SHR, ALU_SUBN, ALU_SHL
  } alu_op_t;

  typedef enum logic {IDLE, EXEC} exec_state_t;

endpackage

// File: rtl/chip8_alu.sv
// Combinational CHIP-8 ALU: a_i is VX, b_i is VY (or NN for the 6/7 groups).
module chip8_alu
  import chip8_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SHIFT_QUIRK = 0,
  parameter int VF_RESET    = 1
) (
  input  alu_op_t           op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              flag_o,
  output logic              flag_we_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] src;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign src = (SHIFT_QUIRK != 0) ? a_i : b_i;

  always_comb begin
    result_o  = b_i;
    flag_o    = 1'b0;
    flag_we_o = 1'b0;
    case (op_i)
      ALU_MOV: result_o = b_i;
      ALU_OR:  begin result_o = a_i | b_i; flag_we_o = (VF_RESET != 0); end
      ALU_AND: begin result_o = a_i & b_i; flag_we_o = (VF_RESET != 0); end
      ALU_XOR: begin result_o = a_i ^ b_i; flag_we_o = (VF_RESET != 0); end
      ALU_ADD: begin
        result_o  = sum[DATA_W-1:0];
        flag_o    = sum[DATA_W];
        flag_we_o = 1'b1;
      end
      ALU_SUB: begin
        result_o  = a_i - b_i;
        flag_o    = (a_i >= b_i);
        flag_we_o = 1'b1;
      end
      ALU_SHR: begin
        result_o  = src >> 1;
        flag_o    = src[0];
        flag_we_o = 1'b1;
      end
      ALU_SUBN: begin
        result_o  = b_i - a_i;
        flag_o    = (b_i >= a_i);
        flag_we_o = 1'b1;
      end
      ALU_SHL: begin
        result_o  = src << 1;
        flag_o    = src[DATA_W-1];
        flag_we_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/chip8_exec_unit.sv
// CHIP-8 V register file plus a two-state executor for the 6XNN/7XNN/8XYn groups.
// Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
module chip8_exec_unit
  import chip8_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 16,
  parameter int SHIFT_QUIRK = 0,
  parameter int VF_RESET    = 1
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  input  logic [15:0]       instruction,
  output logic              instr_ready,
  output logic              done,
  output logic              illegal,
  input  logic [3:0]        testIn1,
  input  logic [3:0]        testIn2,
  output logic [DATA_W-1:0] testOut1,
  output logic [DATA_W-1:0] testOut2,
  output logic              dbg_state
);

  localparam int FLAG_IDX = NUM_REGS - 1;

  exec_state_t       state_q;
  logic [15:0]       instr_q;
  logic [DATA_W-1:0] vx_q, vy_q;
  logic              done_q, illegal_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // 16-entry view so any 4-bit index is safe; missing registers read as zero.
  logic [DATA_W-1:0] view [16];
  for (genvar g = 0; g < 16; g++) begin : g_view
    if (g < NUM_REGS) begin : g_real
      assign view[g] = regs_q[g];
    end else begin : g_pad
      assign view[g] = '0;
    end
  end

  logic [3:0]        x_idx, y_idx;
  logic              x_ok, y_ok, legal, no_flag;
  logic [DATA_W-1:0] operand_b, nn_ext;
  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_flag, alu_flag_we;

  assign x_idx  = instr_q[11:8];
  assign y_idx  = instr_q[7:4];
  assign nn_ext = DATA_W'(instr_q[7:0]);
  assign x_ok   = {1'b0, x_idx} < 5'(NUM_REGS);
  assign y_ok   = {1'b0, y_idx} < 5'(NUM_REGS);

  always_comb begin
    alu_op    = ALU_MOV;
    legal     = 1'b0;
    no_flag   = 1'b0;
    operand_b = vy_q;
    case (instr_q[15:12])
      OP_LD: begin
        legal     = x_ok;
        operand_b = nn_ext;
      end
      OP_ADD: begin
        alu_op    = ALU_ADD;
        legal     = x_ok;
        no_flag   = 1'b1;
        operand_b = nn_ext;
      end
      OP_ALU: begin
        legal = x_ok && y_ok;
        case (instr_q[3:0])
          4'h0: alu_op = ALU_MOV;
          4'h1: alu_op = ALU_OR;
          4'h2: alu_op = ALU_AND;
          4'h3: alu_op = ALU_XOR;
          4'h4: alu_op = ALU_ADD;
          4'h5: alu_op = ALU_SUB;
          4'h6: alu_op = ALU_SHR;
          4'h7: alu_op = ALU_SUBN;
          4'hE: alu_op = ALU_SHL;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  chip8_alu #(
    .DATA_W     (DATA_W),
    .SHIFT_QUIRK(SHIFT_QUIRK),
    .VF_RESET   (VF_RESET)
  ) u_alu (
    .op_i     (alu_op),
    .a_i      (vx_q),
    .b_i      (operand_b),
    .result_o (alu_result),
    .flag_o   (alu_flag),
    .flag_we_o(alu_flag_we)
  );

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instruction;
            vx_q    <= view[instruction[11:8]];
            vy_q    <= view[instruction[7:4]];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          state_q <= IDLE;
          if (legal) begin
            done_q <= 1'b1;
            // Flag assignment comes last so it overrides a result aimed at VF.
            for (int i = 0; i < NUM_REGS; i++) begin
              if (4'(i) == x_idx) regs_q[i] <= alu_result;
              if (i == FLAG_IDX && alu_flag_we && !no_flag) regs_q[i] <= DATA_W'(alu_flag);
            end
          end else begin
            illegal_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign dbg_state   = state_q;
  assign testOut1    = view[testIn1];
  assign testOut2    = view[testIn2];

endmodule

// File: tb/tb_chip8_exec_unit.sv
// Bench for chip8_exec_unit: four parameter variants against a behavioural register model.
module tb_chip8_exec_unit;
  import chip8_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld   [4];
  logic [15:0] ins   [4];
  logic [3:0]  rd_a  [4];
  logic [3:0]  rd_b  [4];
  wire         rdy   [4];
  wire         dn    [4];
  wire         ill   [4];
  wire         st    [4];
  wire  [11:0] o1    [4];
  wire  [11:0] o2    [4];

  // Variant k: 0 default, 1 SHIFT_QUIRK=1, 2 NUM_REGS=8 + VF_RESET=0, 3 DATA_W=12.
  int          dwa [4] = '{8, 8, 8, 12};
  int          nra [4] = '{16, 16, 8, 16};
  int          sqa [4] = '{0, 1, 0, 0};
  int          vra [4] = '{1, 1, 0, 1};
  int unsigned mv  [4][16];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DW = (g == 3) ? 12 : 8;
    localparam int NR = (g == 2) ? 8 : 16;
    localparam int SQ = (g == 1) ? 1 : 0;
    localparam int VR = (g == 2) ? 0 : 1;
    logic [DW-1:0] t1, t2;
    chip8_exec_unit #(.DATA_W(DW), .NUM_REGS(NR), .SHIFT_QUIRK(SQ), .VF_RESET(VR)) u_dut (
      .cpu_clk(clk), .reset_n(rst_n), .instr_valid(vld[g]), .instruction(ins[g]),
      .instr_ready(rdy[g]), .done(dn[g]), .illegal(ill[g]),
      .testIn1(rd_a[g]), .testIn2(rd_b[g]), .testOut1(t1), .testOut2(t2),
      .dbg_state(st[g])
    );
    assign o1[g] = 12'(t1);
    assign o2[g] = 12'(t2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference semantics of one instruction; returns 1 when the opcode is illegal.
  function automatic bit model_exec(int k, logic [15:0] op);
    int unsigned mask = (32'd1 << dwa[k]) - 1;
    int unsigned x = op[11:8], y = op[7:4], nn = op[7:0] & mask;
    int unsigned a, b, src, res, flag;
    bit fw;
    if (x >= nra[k]) return 1;
    if (op[15:12] == 4'h6) begin mv[k][x] = nn; return 0; end
    if (op[15:12] == 4'h7) begin mv[k][x] = (mv[k][x] + nn) & mask; return 0; end
    if (op[15:12] != 4'h8 || y >= nra[k]) return 1;
    a = mv[k][x]; b = mv[k][y]; src = (sqa[k] != 0) ? a : b;
    flag = 0; fw = 1;
    case (op[3:0])
      4'h0: begin res = b; fw = 0; end
      4'h1: begin res = a | b; fw = (vra[k] != 0); end
      4'h2: begin res = a & b; fw = (vra[k] != 0); end
      4'h3: begin res = a ^ b; fw = (vra[k] != 0); end
      4'h4: begin res = (a + b) & mask; flag = ((a + b) > mask) ? 1 : 0; end
      4'h5: begin res = (a - b) & mask; flag = (a >= b) ? 1 : 0; end
      4'h6: begin res = src / 2; flag = src % 2; end
      4'h7: begin res = (b - a) & mask; flag = (b >= a) ? 1 : 0; end
      4'hE: begin res = (src * 2) & mask; flag = (src >> (dwa[k] - 1)) & 1; end
      default: return 1;
    endcase
    mv[k][x] = res;
    if (fw) mv[k][nra[k] - 1] = flag;
    return 0;
  endfunction

  function automatic int unsigned exp_reg(int k, int i);
    return (i < nra[k]) ? mv[k][i] : 0;
  endfunction

  task automatic rd(input int k, input int i, output logic [11:0] v);
    rd_a[k] = 4'(i);
    #1 v = o1[k];
  endtask

  task automatic check_regs(input int k);
    for (int i = 0; i < 8; i++) begin
      rd_a[k] = 4'(i);
      rd_b[k] = 4'(i + 8);
      #1;
      check("reg_lo", 32'(o1[k]), exp_reg(k, i));
      check("reg_hi", 32'(o2[k]), exp_reg(k, i + 8));
    end
  endtask

  task automatic issue(input int k, input logic [15:0] op);
    bit exp_ill;
    int guard = 0;
    @(negedge clk);
    while (!rdy[k] && guard < 8) begin @(negedge clk); guard++; end
    check("ready_idle", 32'(rdy[k]), 1);
    vld[k] = 1'b1;
    ins[k] = op;
    @(posedge clk);
    #1 vld[k] = 1'b0;
    exp_ill = model_exec(k, op);
    @(negedge clk);
    check("busy_ready", 32'(rdy[k]), 0);
    check("busy_state", 32'(st[k]), 32'(EXEC));
    check("busy_done", 32'(dn[k]), 0);
    @(negedge clk);
    check("done_pulse", 32'(dn[k]), 32'(!exp_ill));
    check("illegal_pulse", 32'(ill[k]), 32'(exp_ill));
    check_regs(k);
  endtask

  function automatic logic [15:0] rand_op();
    logic [3:0] nlist [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
    int r = $urandom_range(0, 9);
    logic [3:0] x = 4'($urandom_range(0, 15));
    logic [3:0] y = 4'($urandom_range(0, 15));
    logic [7:0] nn = 8'($urandom_range(0, 255));
    if (r < 2) return {4'h6, x, nn};
    if (r < 4) return {4'h7, x, nn};
    if (r < 9) return {4'h8, x, y, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                              : nlist[$urandom_range(0, 8)]};
    return 16'($urandom);
  endfunction

  logic [11:0] v;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vld[k] = 1'b0; ins[k] = '0; rd_a[k] = '0; rd_b[k] = '0;
      for (int i = 0; i < 16; i++) mv[k][i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_ready", 32'(rdy[k]), 1);
      check("rst_done", 32'(dn[k]), 0);
      check("rst_illegal", 32'(ill[k]), 0);
      check_regs(k);
    end
    rst_n = 1'b1;

    // Directed sequence on the default variant.
    issue(0, 16'h6122); issue(0, 16'h6020); issue(0, 16'h8014);
    rd(0, 0, v); check("v0_42", 32'(v), 32'h42);
    rd(0, 1, v); check("v1_22", 32'(v), 32'h22);
    rd(0, 15, v); check("vf_0", 32'(v), 0);
    issue(0, 16'h8014); rd(0, 0, v); check("v0_64", 32'(v), 32'h64);
    issue(0, 16'h8013); rd(0, 0, v); check("v0_46", 32'(v), 32'h46);
    issue(0, 16'h8015); rd(0, 0, v); check("v0_24", 32'(v), 32'h24);
    rd(0, 15, v); check("vf_sub", 32'(v), 1);
    issue(0, 16'h8017); rd(0, 0, v); check("v0_fe", 32'(v), 32'hFE);
    rd(0, 15, v); check("vf_subn", 32'(v), 0);
    issue(0, 16'h60FF); issue(0, 16'h6101); issue(0, 16'h8014);
    rd(0, 0, v); check("carry_v0", 32'(v), 0);
    rd(0, 15, v); check("carry_vf", 32'(v), 1);
    issue(0, 16'h6FFF); issue(0, 16'h8F14);
    rd(0, 15, v); check("vf_wins", 32'(v), 1);

    for (int k = 0; k < 2; k++) begin
      issue(k, 16'h6181); issue(k, 16'h6003); issue(k, 16'h8016);
      rd(k, 0, v); check("shr_v0", 32'(v), (k == 0) ? 32'h40 : 32'h01);
      rd(k, 15, v); check("shr_vf", 32'(v), 1);
    end
    issue(0, 16'h801F);
    issue(2, 16'h6922);

    // Valid held with a new opcode while busy: only taken once ready returns.
    issue(0, 16'h6155);
    @(negedge clk);
    vld[0] = 1'b1; ins[0] = 16'h6011;
    @(posedge clk);
    #1 ins[0] = 16'h6122;
    void'(model_exec(0, 16'h6011));
    @(negedge clk);
    check("hold_busy", 32'(rdy[0]), 0);
    @(negedge clk);
    check("hold_done_a", 32'(dn[0]), 1);
    rd(0, 0, v); check("hold_v0", 32'(v), 32'h11);
    rd(0, 1, v); check("hold_v1_old", 32'(v), 32'h55);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    void'(model_exec(0, 16'h6122));
    @(negedge clk);
    check("hold_busy_b", 32'(rdy[0]), 0);
    @(negedge clk);
    check("hold_done_b", 32'(dn[0]), 1);
    rd(0, 1, v); check("hold_v1_new", 32'(v), 32'h22);

    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 60; n++) issue(k, rand_op());

    // Reset while an instruction is in flight.
    issue(0, 16'h6033);
    @(negedge clk);
    vld[0] = 1'b1; ins[0] = 16'h6055;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) for (int i = 0; i < 16; i++) mv[k][i] = 0;
    check("rst_async_ready", 32'(rdy[0]), 1);
    check("rst_async_done", 32'(dn[0]), 0);
    rd(0, 0, v); check("rst_async_v0", 32'(v), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_done", 32'(dn[0]), 0);
    check_regs(0);

    issue(3, 16'h60FF); issue(3, 16'h7001);
    rd(3, 0, v); check("w12_v0", 32'(v), 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
